acc_drain: RTL

ACC_DRAIN -- requirements
Module: acc_drain

---
 rtl/acc_drain.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/acc_drain.sv
// acc_drain: reads accumulator rows through a one-cycle-latency read port and
// streams each row out lane by lane over a valid/ready channel.
// Lane 0 of each row goes out first. Each lane is sign-extended to 32 bits.
// Optional build macro ACC_DRAIN_RELU_EN: negative lanes are output as zero and
// non-negative lanes are zero-extended. Beat timing is the same in both builds.
// Lanes are assumed to be no wider than 32 bits (LANE_W <= 32).
module acc_drain #(
    parameter int LANES  = 16,
    parameter int LANE_W = 20,
    parameter int ADDR_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ADDR_W:0]           row_count,
    output logic                      busy,
    output logic                      done,
    output logic                      acc_enb,
    output logic [ADDR_W-1:0]         acc_addrb,
    input  logic [LANES*LANE_W-1:0]   acc_doutb,
    output logic [31:0]               m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last
);

    localparam int ROW_W      = LANES * LANE_W;
    localparam int CNT_W      = ADDR_W + 1;
    localparam int LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        CAP  = 3'd2,
        SEND = 3'd3,
        FIN  = 3'd4
    } state_t;

    // Extracts lane idx from a row and widens it to a 32-bit beat.
    function automatic logic [31:0] lane_ext(input logic [ROW_W-1:0]      row,
                                             input logic [LANE_IDX_W-1:0] idx);
        logic [LANE_W-1:0] lane;
        lane = LANE_W'(row >> (int'(idx) * LANE_W));
`ifdef ACC_DRAIN_RELU_EN
        lane_ext = lane[LANE_W-1] ? 32'h0000_0000 : {{(32-LANE_W){1'b0}}, lane};
`else
        lane_ext = {{(32-LANE_W){lane[LANE_W-1]}}, lane};
`endif
    endfunction

    state_t                 state_r, state_nxt_s;
    logic [ADDR_W-1:0]      row_ptr_r, row_ptr_nxt_s;
    logic [CNT_W-1:0]       remain_r, remain_nxt_s;
    logic [LANE_IDX_W-1:0]  lane_r, lane_nxt_s;
    logic [ROW_W-1:0]       row_r, row_nxt_s;

    logic                   busy_r, busy_nxt_s;
    logic                   done_r, done_nxt_s;
    logic                   acc_enb_r, acc_enb_nxt_s;
    logic [ADDR_W-1:0]      acc_addrb_r, acc_addrb_nxt_s;
    logic [31:0]            m_data_r, m_data_nxt_s;
    logic                   m_valid_r, m_valid_nxt_s;
    logic                   m_last_r, m_last_nxt_s;

    logic                   handshake_s;
    logic                   final_row_s;
    logic [LANE_IDX_W-1:0]  lane_inc_s;
    logic [ADDR_W-1:0]      row_ptr_inc_s;

    assign handshake_s   = m_valid_r & m_ready;
    assign final_row_s   = (remain_r == CNT_W'(1));
    assign lane_inc_s    = lane_r + LANE_IDX_W'(1);
    assign row_ptr_inc_s = row_ptr_r + ADDR_W'(1);

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_nxt_s     = state_r;
        row_ptr_nxt_s   = row_ptr_r;
        remain_nxt_s    = remain_r;
        lane_nxt_s      = lane_r;
        row_nxt_s       = row_r;
        done_nxt_s      = 1'b0;
        acc_enb_nxt_s   = 1'b0;
        acc_addrb_nxt_s = acc_addrb_r;
        m_data_nxt_s    = m_data_r;
        m_valid_nxt_s   = 1'b0;
        m_last_nxt_s    = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    if (row_count != CNT_W'(0)) begin
                        state_nxt_s     = REQ;
                        row_ptr_nxt_s   = base_addr;
                        remain_nxt_s    = row_count;
                        acc_enb_nxt_s   = 1'b1;
                        acc_addrb_nxt_s = base_addr;
                    end else begin
                        state_nxt_s = FIN;
                        done_nxt_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                // Read issued this cycle; data arrives during CAP.
                state_nxt_s = CAP;
            end
            CAP: begin
                row_nxt_s     = acc_doutb;
                lane_nxt_s    = LANE_IDX_W'(0);
                state_nxt_s   = SEND;
                m_valid_nxt_s = 1'b1;
                m_data_nxt_s  = lane_ext(acc_doutb, LANE_IDX_W'(0));
                m_last_nxt_s  = final_row_s && (LAST_LANE == LANE_IDX_W'(0));
            end
            SEND: begin
                if (handshake_s) begin
                    if (lane_r == LAST_LANE) begin
                        remain_nxt_s  = remain_r - CNT_W'(1);
                        row_ptr_nxt_s = row_ptr_inc_s;
                        if (final_row_s) begin
                            state_nxt_s = FIN;
                            done_nxt_s  = 1'b1;
                        end else begin
                            state_nxt_s     = REQ;
                            acc_enb_nxt_s   = 1'b1;
                            acc_addrb_nxt_s = row_ptr_inc_s;
                        end
                    end else begin
                        lane_nxt_s    = lane_inc_s;
                        m_valid_nxt_s = 1'b1;
                        m_data_nxt_s  = lane_ext(row_r, lane_inc_s);
                        m_last_nxt_s  = final_row_s && (lane_inc_s == LAST_LANE);
                    end
                end else begin
                    // Stalled: hold the presented beat unchanged.
                    m_valid_nxt_s = m_valid_r;
                    m_last_nxt_s  = m_last_r;
                end
            end
            FIN: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            row_ptr_r   <= {ADDR_W{1'b0}};
            remain_r    <= {CNT_W{1'b0}};
            lane_r      <= {LANE_IDX_W{1'b0}};
            row_r       <= {ROW_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            acc_enb_r   <= 1'b0;
            acc_addrb_r <= {ADDR_W{1'b0}};
            m_data_r    <= 32'h0000_0000;
            m_valid_r   <= 1'b0;
            m_last_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            row_ptr_r   <= row_ptr_nxt_s;
            remain_r    <= remain_nxt_s;
            lane_r      <= lane_nxt_s;
            row_r       <= row_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            acc_enb_r   <= acc_enb_nxt_s;
            acc_addrb_r <= acc_addrb_nxt_s;
            m_data_r    <= m_data_nxt_s;
            m_valid_r   <= m_valid_nxt_s;
            m_last_r    <= m_last_nxt_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign acc_enb   = acc_enb_r;
    assign acc_addrb = acc_addrb_r;
    assign m_data    = m_data_r;
    assign m_valid   = m_valid_r;
    assign m_last    = m_last_r;

endmodule
